// File: rtl/set_seq.sv
// set_seq: walks a small pattern buffer, hands one pattern at a time to a downstream
// SET core and collects one result byte per pattern, with a per-pattern timeout.
module set_seq #(
    parameter int unsigned TIMEOUT  = 1023,
    parameter int unsigned NPAT_MAX = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [23:0] wr_central,
    input  logic [11:0] wr_radius,
    input  logic        start,
    input  logic [6:0]  num_pat,
    input  logic [1:0]  mode_in,
    output logic        en,
    output logic [23:0] central,
    output logic [11:0] radius,
    output logic [1:0]  mode,
    input  logic        busy,
    input  logic        valid,
    input  logic [7:0]  candidate,
    input  logic [5:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic        run,
    output logic        done,
    output logic [6:0]  tmo_cnt
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitV,
        StStore,
        StFin
    } state_e;

    state_e          state_q, state_d;
    logic [6:0]      idx_q, idx_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [CW-1:0]   wcnt_q, wcnt_d;
    logic [7:0]      res_q, res_d;
    logic [6:0]      tmo_q, tmo_d;
    logic [1:0]      mode_q, mode_d;
    logic [23:0]     central_q, central_d;
    logic [11:0]     radius_q, radius_d;
    logic            pat_we;
    logic            res_we;
    logic            load_pat;
    logic [6:0]      npat_sat;
    logic [5:0]      load_addr;

    logic [23:0]     pat_central [NPAT_MAX];
    logic [11:0]     pat_radius  [NPAT_MAX];
    logic [7:0]      res_mem     [NPAT_MAX];

    assign npat_sat  = (num_pat > 7'(NPAT_MAX)) ? 7'(NPAT_MAX) : num_pat;
    assign load_addr = idx_d[5:0];

    // Next-state, datapath updates and strobes for the sequencer FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        res_d     = res_q;
        tmo_d     = tmo_q;
        mode_d    = mode_q;
        central_d = central_q;
        radius_d  = radius_q;
        en        = 1'b0;
        done      = 1'b0;
        pat_we    = 1'b0;
        res_we    = 1'b0;
        load_pat  = 1'b0;
        unique case (state_q)
            StIdle: begin
                pat_we = wr_en;
                if (start) begin
                    idx_d  = 7'd0;
                    tmo_d  = 7'd0;
                    mode_d = mode_in;
                    cnt_d  = npat_sat;
                    if (npat_sat == 7'd0) begin
                        state_d = StFin;
                    end else begin
                        state_d  = StIssue;
                        load_pat = 1'b1;
                    end
                end
            end
            StIssue: begin
                if (!busy) begin
                    en      = 1'b1;
                    wcnt_d  = '0;
                    state_d = StWaitV;
                end
            end
            StWaitV: begin
                if (valid) begin
                    res_d   = candidate;
                    state_d = StStore;
                end else if (wcnt_q == CW'(TIMEOUT)) begin
                    res_d   = 8'hFF;
                    tmo_d   = tmo_q + 7'd1;
                    state_d = StStore;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
            end
            StStore: begin
                res_we = 1'b1;
                idx_d  = idx_q + 7'd1;
                if (idx_d == cnt_q) begin
                    state_d = StFin;
                end else begin
                    state_d  = StIssue;
                    load_pat = 1'b1;
                end
            end
            StFin: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Present the next pattern on entry to ISSUE; a same-cycle write to that entry wins.
        if (load_pat) begin
            if (pat_we && (wr_addr == load_addr)) begin
                central_d = wr_central;
                radius_d  = wr_radius;
            end else begin
                central_d = pat_central[load_addr];
                radius_d  = pat_radius[load_addr];
            end
        end
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= 7'd0;
            cnt_q     <= 7'd0;
            wcnt_q    <= '0;
            res_q     <= 8'd0;
            tmo_q     <= 7'd0;
            mode_q    <= 2'd0;
            central_q <= 24'd0;
            radius_q  <= 12'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            res_q     <= res_d;
            tmo_q     <= tmo_d;
            mode_q    <= mode_d;
            central_q <= central_d;
            radius_q  <= radius_d;
        end
    end

    // Pattern and result buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pat_central[wr_addr] <= wr_central;
            pat_radius[wr_addr]  <= wr_radius;
        end
        if (res_we) begin
            res_mem[idx_q[5:0]] <= res_q;
        end
    end

    assign rd_data = res_mem[rd_addr];
    assign run     = (state_q != StIdle);
    assign central = central_q;
    assign radius  = radius_q;
    assign mode    = mode_q;
    assign tmo_cnt = tmo_q;

endmodule

// File: tb/tb_set_seq.sv
// tb_set_seq: scoreboard bench for set_seq with a small SET-core responder model.
module tb_set_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [23:0] wr_central;
    logic [11:0] wr_radius;
    logic        start;
    logic [6:0]  num_pat;
    logic [1:0]  mode_in;
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        run;
    logic        done;
    logic [6:0]  tmo_cnt;

    set_seq #(
        .TIMEOUT (15),
        .NPAT_MAX(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_central(wr_central),
        .wr_radius (wr_radius),
        .start     (start),
        .num_pat   (num_pat),
        .mode_in   (mode_in),
        .en        (en),
        .central   (central),
        .radius    (radius),
        .mode      (mode),
        .busy      (busy),
        .valid     (valid),
        .candidate (candidate),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .run       (run),
        .done      (done),
        .tmo_cnt   (tmo_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int last_en = -100;
    int s_cyc = 0;
    int vcnt = 0;
    bit model_on = 1'b0;

    int exp_c[$];
    int exp_r[$];
    int exp_res[$];
    int resp[$];
    int shadow_c[64];
    int shadow_r[64];

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observe en/done away from the clock edge and compare against the pattern scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (en) begin
                check_eq("en_busy_low", int'(busy), 0);
                check_eq("en_gap", int'((cyc - last_en) >= 3), 1);
                check_eq("en_expected", int'(exp_c.size() > 0), 1);
                if (exp_c.size() > 0) begin
                    check_eq("en_central", int'(central), exp_c.pop_front());
                    check_eq("en_radius", int'(radius), exp_r.pop_front());
                end
                last_en = cyc;
                en_cnt++;
                if (model_on) vcnt = 5;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // SET core model: answers valid five cycles after each en.
    always @(posedge clk) begin
        #1;
        valid = 1'b0;
        if (vcnt > 0) begin
            vcnt--;
            if (vcnt == 0 && resp.size() > 0) begin
                valid     = 1'b1;
                candidate = 8'(resp.pop_front());
            end
        end
    end

    task automatic write_pat(input int a, input int c, input int r);
        wr_en      = 1'b1;
        wr_addr    = 6'(a);
        wr_central = 24'(c);
        wr_radius  = 12'(r);
        shadow_c[a] = c & 24'hFFFFFF;
        shadow_r[a] = r & 12'hFFF;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic push_pats(input int n);
        for (int i = 0; i < n; i++) begin
            exp_c.push_back(shadow_c[i]);
            exp_r.push_back(shadow_r[i]);
        end
    endtask

    task automatic push_resp(input int v);
        resp.push_back(v);
        exp_res.push_back(v);
    endtask

    task automatic start_run(input int n, input int m);
        start   = 1'b1;
        num_pat = 7'(n);
        mode_in = 2'(m);
        s_cyc   = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("done_once", done_cnt, d0 + 1);
    endtask

    task automatic read_res(input int n);
        for (int i = 0; i < n; i++) begin
            rd_addr = 6'(i);
            #1;
            if (exp_res.size() > 0) check_eq($sformatf("rd_data[%0d]", i), int'(rd_data),
                                             exp_res.pop_front());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e0;
        int d0;
        int k;
        rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_central = '0; wr_radius = '0;
        start = 1'b0; num_pat = '0; mode_in = '0; busy = 1'b0; valid = 1'b0;
        candidate = '0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_en", int'(en), 0);
        check_eq("rst_run", int'(run), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_central", int'(central), 0);
        check_eq("rst_radius", int'(radius), 0);
        check_eq("rst_mode", int'(mode), 0);
        check_eq("rst_tmo", int'(tmo_cnt), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Three patterns, responder returns 0A/14/1E.
        write_pat(0, 24'h123456, 12'h0AB);
        write_pat(1, 24'hABCDEF, 12'h321);
        write_pat(2, 24'h0F0F0F, 12'hFFF);
        model_on = 1'b1;
        e0 = en_cnt; d0 = done_cnt;
        push_pats(3);
        push_resp(8'h0A); push_resp(8'h14); push_resp(8'h1E);
        start_run(3, 2);
        check_eq("run_high", int'(run), 1);
        wait_done(d0, 200);
        check_eq("a_en_count", en_cnt - e0, 3);
        check_eq("a_tmo", int'(tmo_cnt), 0);
        check_eq("a_mode", int'(mode), 2);
        check_eq("a_run_low", int'(run), 0);
        read_res(3);

        // busy held high for 10 cycles after start.
        busy = 1'b1;
        e0 = en_cnt; d0 = done_cnt;
        push_pats(1);
        push_resp(8'h55);
        start_run(1, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check_eq("b_no_en_busy", en_cnt - e0, 0);
        busy = 1'b0;
        @(negedge clk);
        check_eq("b_en_on_fall", int'(en), 1);
        @(posedge clk); #1;
        wait_done(d0, 100);
        check_eq("b_en_count", en_cnt - e0, 1);
        read_res(1);

        // Responder silent: both patterns time out.
        model_on = 1'b0;
        e0 = en_cnt; d0 = done_cnt;
        push_pats(2);
        exp_res.push_back(8'hFF); exp_res.push_back(8'hFF);
        start_run(2, 0);
        wait_done(d0, 200);
        check_eq("c_done_latency", done_cyc - s_cyc, 37);
        check_eq("c_tmo", int'(tmo_cnt), 2);
        check_eq("c_en_count", en_cnt - e0, 2);
        read_res(2);

        // num_pat = 0 finishes immediately.
        e0 = en_cnt; d0 = done_cnt;
        start_run(0, 1);
        wait_done(d0, 10);
        check_eq("d0_done_latency", done_cyc - s_cyc, 1);
        check_eq("d0_en_count", en_cnt - e0, 0);

        // num_pat = 100 saturates to 64.
        for (int i = 0; i < 64; i++) write_pat(i, (i * 24'h010203) ^ 24'h5A5A5A, i * 37 + 5);
        model_on = 1'b1;
        e0 = en_cnt; d0 = done_cnt;
        push_pats(64);
        for (int i = 0; i < 64; i++) push_resp((i * 7 + 3) & 255);
        start_run(100, 3);
        wait_done(d0, 1000);
        check_eq("d_en_count", en_cnt - e0, 64);
        check_eq("d_tmo", int'(tmo_cnt), 0);
        read_res(64);

        // Reset while waiting on pattern 1.
        e0 = en_cnt; d0 = done_cnt;
        push_pats(2);
        push_resp(8'h11); push_resp(8'h22);
        start_run(2, 3);
        k = 0;
        while (en_cnt < e0 + 2 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq("e_second_en", en_cnt - e0, 2);
        #1;
        rst = 1'b0;
        #1;
        check_eq("e_en", int'(en), 0);
        check_eq("e_run", int'(run), 0);
        check_eq("e_central", int'(central), 0);
        check_eq("e_radius", int'(radius), 0);
        check_eq("e_mode", int'(mode), 0);
        check_eq("e_tmo", int'(tmo_cnt), 0);
        vcnt = 0; valid = 1'b0;
        resp.delete(); exp_c.delete(); exp_r.delete(); exp_res.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        check_eq("e_no_done", done_cnt, d0);
        rd_addr = 6'd0;
        #1;
        check_eq("e_res_kept", int'(rd_data), 8'h11);

        // Fresh run, write to entry 0 in the same cycle as start.
        e0 = en_cnt; d0 = done_cnt;
        wr_en = 1'b1; wr_addr = 6'd0; wr_central = 24'hC0FFEE; wr_radius = 12'h777;
        shadow_c[0] = 24'hC0FFEE; shadow_r[0] = 12'h777;
        push_pats(2);
        push_resp(8'h33); push_resp(8'h44);
        start = 1'b1; num_pat = 7'd2; mode_in = 2'd1; s_cyc = cyc;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        wait_done(d0, 100);
        check_eq("e2_en_count", en_cnt - e0, 2);
        read_res(2);

        // start/wr_en during a run are ignored.
        e0 = en_cnt; d0 = done_cnt;
        push_pats(3);
        push_resp(8'hA1); push_resp(8'hA2); push_resp(8'hA3);
        start_run(3, 0);
        k = 0;
        while (en_cnt < e0 + 1 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        wr_en = 1'b1; wr_addr = 6'd1; wr_central = 24'hDEAD00; wr_radius = 12'hBAD;
        start = 1'b1; num_pat = 7'd1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        wait_done(d0, 200);
        check_eq("f_en_count", en_cnt - e0, 3);
        read_res(3);
        e0 = en_cnt; d0 = done_cnt;
        push_pats(2);
        push_resp(8'hB1); push_resp(8'hB2);
        start_run(2, 0);
        wait_done(d0, 100);
        check_eq("f2_en_count", en_cnt - e0, 2);
        read_res(2);
        check_eq("pat_queue_empty", exp_c.size(), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
